// File: rtl/spmp_csr_regfile_pkg.sv
// Shared types and select-space constants for the SPMP CSR register file.
// The checkers use spmpcfg_t as the per-entry configuration byte.
package spmp_csr_regfile_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef struct packed {
    logic       s;
    logic [1:0] rsvd;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } spmpcfg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RESP
  } spmp_state_e;

  localparam logic [7:0] SPMP_SEL_ADDR_BASE = 8'h00;
  localparam logic [7:0] SPMP_SEL_CFG_BASE  = 8'h40;
  localparam logic [7:0] SPMP_SEL_SWITCH_LO = 8'h80;
  localparam logic [7:0] SPMP_SEL_SWITCH_HI = 8'h81;

  // One bit set for every implemented entry.
  function automatic logic [63:0] entry_mask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/spmp_csr_regfile_if.sv
// CSR-side request/response bus plus the downstream flush handshake.
interface spmp_csr_regfile_if #(
  parameter int XLEN = 64
) ();
  import spmp_csr_regfile_pkg::*;

  priv_lvl_t         priv_lvl;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [7:0]        req_sel;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_illegal;
  logic              flush;
  logic              flush_ack;

  modport master (
    output priv_lvl, req_valid, req_we, req_sel, req_wdata, flush_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal, flush
  );

  modport slave (
    input  priv_lvl, req_valid, req_we, req_sel, req_wdata, flush_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal, flush
  );

endinterface

// File: rtl/spmp_cfg_legalize.sv
// WARL legalisation of one spmpcfg byte: W-without-R writes are dropped,
// reserved bits are forced to zero.
module spmp_cfg_legalize
  import spmp_csr_regfile_pkg::*;
(
  input  spmpcfg_t   old_cfg,
  input  logic [7:0] wbyte,
  output spmpcfg_t   new_cfg,
  output logic       changed
);

  always_comb begin
    new_cfg      = spmpcfg_t'(wbyte);
    new_cfg.rsvd = '0;
    if (wbyte[1] && !wbyte[0]) new_cfg = old_cfg;
    changed = (new_cfg != old_cfg);
  end

endmodule

// File: rtl/spmp_csr_regfile.sv
// SPMP architectural state and programming engine: legalises CSR writes and
// holds the response until downstream checkers have flushed stale state.
module spmp_csr_regfile
  import spmp_csr_regfile_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int PLEN          = 56,
  parameter int NrSPMPEntries = 16,
  parameter int Granularity   = 0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  spmp_csr_regfile_if.slave                       bus,
  output spmpcfg_t [NrSPMPEntries-1:0]            spmpcfg_o,
  output logic     [NrSPMPEntries-1:0][PLEN-3:0]  spmpaddr_o,
  output logic     [63:0]                         spmpswitch_o
);

  localparam int              AW      = PLEN - 2;
  localparam logic [63:0]     SW_MASK = entry_mask(NrSPMPEntries);
  localparam logic [AW-1:0]   G_MASK  = AW'((64'd1 << Granularity) - 64'd1);

  spmp_state_e state_q, state_d;
  spmpcfg_t [NrSPMPEntries-1:0]         cfg_q, cfg_new;
  logic     [NrSPMPEntries-1:0]         cfg_chg;
  logic     [NrSPMPEntries-1:0][AW-1:0] addr_q;
  logic     [63:0]                      sw_q, sw_new;
  logic     [AW-1:0]                    addr_new;
  logic     [XLEN-1:0]                  rdata_q, rd_val;
  logic                                 illegal_q;

  logic [5:0] idx;
  logic       is_addr, is_cfg, is_sw_lo, is_sw_hi, illegal;
  logic       accept, wr_en, wr_chg;

  always_comb begin
    idx      = bus.req_sel[5:0];
    is_addr  = (bus.req_sel[7:6] == SPMP_SEL_ADDR_BASE[7:6]);
    is_cfg   = (bus.req_sel[7:6] == SPMP_SEL_CFG_BASE[7:6]);
    is_sw_lo = (bus.req_sel == SPMP_SEL_SWITCH_LO);
    is_sw_hi = (bus.req_sel == SPMP_SEL_SWITCH_HI) && (XLEN == 32);
    illegal  = (bus.priv_lvl == PRIV_LVL_U)
            || ((is_addr || is_cfg) && ({1'b0, idx} >= 7'(NrSPMPEntries)))
            || !(is_addr || is_cfg || is_sw_lo || is_sw_hi);
    accept   = bus.req_valid && (state_q == ST_IDLE);
    wr_en    = accept && bus.req_we && !illegal;
  end

  for (genvar i = 0; i < NrSPMPEntries; i++) begin : g_leg
    spmp_cfg_legalize u_leg (
      .old_cfg (cfg_q[i]),
      .wbyte   (bus.req_wdata[7:0]),
      .new_cfg (cfg_new[i]),
      .changed (cfg_chg[i])
    );
  end

  // Upper switch half only exists as its own register on RV32.
  always_comb begin
    addr_new = bus.req_wdata[AW-1:0] & ~G_MASK;
    if (is_sw_hi)        sw_new = {bus.req_wdata[31:0], sw_q[31:0]};
    else if (XLEN == 64) sw_new = 64'(bus.req_wdata);
    else                 sw_new = {sw_q[63:32], bus.req_wdata[31:0]};
    sw_new = sw_new & SW_MASK;
  end

  always_comb begin
    rd_val = '0;
    wr_chg = 1'b0;
    for (int i = 0; i < NrSPMPEntries; i++) begin
      if (idx == 6'(i)) begin
        if (is_cfg)  begin rd_val = XLEN'(cfg_q[i]);  wr_chg = cfg_chg[i];             end
        if (is_addr) begin rd_val = XLEN'(addr_q[i]); wr_chg = (addr_new != addr_q[i]); end
      end
    end
    if (is_sw_lo) rd_val = XLEN'(sw_q);
    if (is_sw_hi) rd_val = XLEN'(sw_q[63:32]);
    if (is_sw_lo || is_sw_hi) wr_chg = (sw_new != sw_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.req_ready   = 1'b0;
    bus.flush       = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_rdata   = '0;
    bus.rsp_illegal = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_d = (wr_en && wr_chg) ? ST_FLUSH : ST_RESP;
      end
      ST_FLUSH: begin
        bus.flush = 1'b1;
        if (bus.flush_ack) state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid   = 1'b1;
        bus.rsp_rdata   = rdata_q;
        bus.rsp_illegal = illegal_q;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q     <= '0;
      addr_q    <= '0;
      sw_q      <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        rdata_q   <= (bus.req_we || illegal) ? '0 : rd_val;
        illegal_q <= illegal;
      end
      if (wr_en) begin
        for (int i = 0; i < NrSPMPEntries; i++) begin
          if (idx == 6'(i)) begin
            if (is_cfg)  cfg_q[i]  <= cfg_new[i];
            if (is_addr) addr_q[i] <= addr_new;
          end
        end
        if (is_sw_lo || is_sw_hi) sw_q <= sw_new;
      end
    end
  end

  assign spmpcfg_o    = cfg_q;
  assign spmpaddr_o   = addr_q;
  assign spmpswitch_o = sw_q;

endmodule
